// File: rtl/mfsk_demod_param.sv
// M-ary symbol demodulator for a 1-bit hard-limited baseband input.
// FSK mode thresholds per-symbol edge counts; PWM mode counts mid-slot samples.
module mfsk_demod_param #(
    parameter int SPS   = 128,
    parameter int BITS  = 2,
    parameter int CNT_W = 8,
    parameter logic [((2**BITS)-1)*CNT_W-1:0] THRESH = {8'd24, 8'd12, 8'd6},
    parameter int TOL   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            din,
    input  logic            sym_tick,
    input  logic            mode,
    output logic [BITS-1:0] dout,
    output logic            dout_valid,
    output logic            len_err
);

    localparam int NS = (2**BITS) - 1;
    localparam logic [CNT_W-1:0] CMAX   = '1;
    localparam logic [CNT_W-1:0] LEN_LO = CNT_W'(SPS - TOL);
    localparam logic [CNT_W-1:0] LEN_HI = CNT_W'(SPS + TOL);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [NS-1:0]    samp_q, samp_d;
    logic             mode_q, mode_d;
    logic             armed_q, armed_d;
    logic [BITS-1:0]  dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             len_err_q, len_err_d;

    logic             tedge;
    logic [BITS-1:0]  fsk_sym;
    logic [BITS-1:0]  pwm_sym;
    logic [BITS-1:0]  sym;
    logic [CNT_W-1:0] len;
    logic             bad_len;
    logic             fire;

    always_comb begin
        s1_d    = din;
        s2_d    = s1_q;
        s3_d    = s2_q;
        tedge   = s2_q ^ s3_q;
        pos_d   = pos_q;
        tcnt_d  = tcnt_q;
        samp_d  = samp_q;
        mode_d  = mode_q;
        armed_d = armed_q;

        // An edge seen in the tick cycle is the first one of the new symbol.
        if (sym_tick) begin
            pos_d   = '0;
            tcnt_d  = CNT_W'(tedge);
            samp_d  = '0;
            mode_d  = mode;
            armed_d = 1'b1;
        end else begin
            if (pos_q != CMAX) begin
                pos_d = pos_q + CNT_W'(1);
            end
            if (tcnt_q != CMAX) begin
                tcnt_d = tcnt_q + CNT_W'(tedge);
            end
            for (int j = 0; j < NS; j++) begin
                if (pos_q == CNT_W'((2 * j + 1) * SPS / (2**(BITS + 1)))) begin
                    samp_d[j] = s2_q;
                end
            end
        end
    end

    always_comb begin
        fsk_sym = '0;
        pwm_sym = '0;
        for (int j = 0; j < NS; j++) begin
            if (tcnt_q >= THRESH[j*CNT_W +: CNT_W]) begin
                fsk_sym = fsk_sym + BITS'(1);
            end
            pwm_sym = pwm_sym + BITS'(samp_q[j]);
        end
        sym     = mode_q ? pwm_sym : fsk_sym;
        len     = (pos_q == CMAX) ? CMAX : pos_q + CNT_W'(1);
        bad_len = (len < LEN_LO) || (len > LEN_HI);

        fire         = sym_tick & armed_q;
        dout_d       = fire ? sym : dout_q;
        dout_valid_d = fire;
        len_err_d    = fire & bad_len;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            pos_q        <= '0;
            tcnt_q       <= '0;
            samp_q       <= '0;
            mode_q       <= 1'b0;
            armed_q      <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            pos_q        <= pos_d;
            tcnt_q       <= tcnt_d;
            samp_q       <= samp_d;
            mode_q       <= mode_d;
            armed_q      <= armed_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            len_err_q    <= len_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign len_err    = len_err_q;

endmodule

// File: tb/tb_mfsk_demod_param.sv
// Bench for mfsk_demod_param: directed plan items plus randomized symbols
// checked every cycle against a history-based behavioural model.
module tb_mfsk_demod_param;

    localparam int SPS = 128;
    localparam int TOL = 2;
    localparam int HN  = 40000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       din = 1'b0;
    logic       sym_tick = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] dout;
    logic       dout_valid;
    logic       len_err;

    mfsk_demod_param dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .sym_tick  (sym_tick),
        .mode      (mode),
        .dout      (dout),
        .dout_valid(dout_valid),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Per-edge input history and expectations, indexed by posedge number.
    bit         dh[HN];
    bit         en[HN];
    bit         ev[HN];
    bit         ee[HN];
    logic [1:0] ed[HN];

    int         cyc = 3;
    bit         armed = 1'b0;
    int         t_prev = 0;
    bit         m_sym = 1'b0;
    logic [1:0] hold = 2'd0;
    logic       cur_din = 1'b0;

    // din is seen two cycles late through the synchroniser, so a symbol
    // bounded by ticks at edges t0,t1 owns transitions t0-2 .. t1-3.
    function automatic logic [1:0] model_sym(int t0, int t1, bit pwm);
        int n;
        int lv;
        int th[3] = '{6, 12, 24};
        lv = 0;
        if (!pwm) begin
            n = 0;
            for (int i = t0 - 2; i <= t1 - 3; i++) begin
                if (dh[i] != dh[i-1]) n++;
            end
            if (n > 255) n = 255;
            for (int j = 0; j < 3; j++) begin
                if (n >= th[j]) lv++;
            end
        end else begin
            for (int j = 0; j < 3; j++) begin
                int p;
                p = (2 * j + 1) * SPS / 8;
                if ((t0 + p + 1 < t1) && dh[t0+p-1]) lv++;
            end
        end
        return 2'(lv);
    endfunction

    task automatic cycle(input bit r, input bit t, input bit d, input bit m);
        int k;
        int len;
        @(negedge clk);
        reset    = r;
        sym_tick = t;
        din      = d;
        mode     = m;
        k = cyc;
        if (k >= HN) begin
            $display("FAIL budget: cycle %0d exceeds history %0d", k, HN);
            $fatal(1, "history overflow");
        end
        dh[k] = d;
        if (r) begin
            dh[k]   = 1'b0;
            dh[k-1] = 1'b0;
            dh[k-2] = 1'b0;
            armed = 1'b0;
            hold  = 2'd0;
            ev[k] = 1'b0;
            ee[k] = 1'b0;
        end else if (t) begin
            ev[k] = armed;
            ee[k] = 1'b0;
            if (armed) begin
                len = k - t_prev;
                if (len > 255) len = 255;
                ee[k] = (len < SPS - TOL) || (len > SPS + TOL);
                hold  = model_sym(t_prev, k, m_sym);
            end
            armed  = 1'b1;
            t_prev = k;
            m_sym  = m;
        end else begin
            ev[k] = 1'b0;
            ee[k] = 1'b0;
        end
        ed[k] = hold;
        en[k] = 1'b1;
        cyc = k + 1;
    endtask

    always @(posedge clk) begin
        int k;
        k = cyc - 1;
        #1;
        if (k >= 0 && k < HN && en[k]) begin
            en[k] = 1'b0;
            vectors++;
            if (dout_valid !== ev[k] || dout !== ed[k] || len_err !== ee[k]) begin
                errors++;
                $display("FAIL model edge%0d: got v=%b d=%0d e=%b, want v=%b d=%0d e=%b",
                         k, dout_valid, dout, len_err, ev[k], ed[k], ee[k]);
            end
        end
    end

    task automatic lit(input string nm, input bit v, input logic [1:0] d, input bit e);
        @(posedge clk);
        #2;
        vectors++;
        if (dout_valid !== v || dout !== d || len_err !== e) begin
            errors++;
            $display("FAIL %s: got v=%b d=%0d e=%b, want v=%b d=%0d e=%b",
                     nm, dout_valid, dout, len_err, v, d, e);
        end
    endtask

    task automatic tick(input bit m);
        cycle(1'b0, 1'b1, cur_din, m);
    endtask

    task automatic body_n(input int len, input int n, input bit m);
        for (int o = 1; o < len; o++) begin
            if (o >= 10 && o < 10 + 2 * n && (o % 2 == 0)) cur_din = ~cur_din;
            cycle(1'b0, 1'b0, cur_din, m);
        end
    endtask

    task automatic body_per(input int len, input int per, input bit m);
        for (int o = 1; o < len; o++) begin
            if (o % per == 0) cur_din = ~cur_din;
            cycle(1'b0, 1'b0, cur_din, m);
        end
    endtask

    task automatic body_pwm(input int len, input int hi, input bit m);
        for (int o = 1; o < len; o++) begin
            cur_din = (o < hi);
            cycle(1'b0, 1'b0, cur_din, m);
        end
    endtask

    initial begin
        int pr[4] = '{0, 3, 10, 20};
        cur_din = 1'b0;
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        lit("reset", 1'b0, 2'd0, 1'b0);

        tick(1'b0);                 lit("arm", 1'b0, 2'd0, 1'b0);
        body_per(128, 10, 1'b0);
        tick(1'b0);                 lit("fsk12", 1'b1, 2'd2, 1'b0);
        body_n(128, 5, 1'b0);
        tick(1'b0);                 lit("th5", 1'b1, 2'd0, 1'b0);
        body_n(128, 6, 1'b0);
        tick(1'b0);                 lit("th6", 1'b1, 2'd1, 1'b0);
        body_n(128, 23, 1'b0);
        tick(1'b0);                 lit("th23", 1'b1, 2'd2, 1'b0);
        body_n(128, 24, 1'b0);
        cur_din = 1'b1;
        tick(1'b1);                 lit("th24", 1'b1, 2'd3, 1'b0);
        body_pwm(128, 50, 1'b1);
        cur_din = 1'b1;
        tick(1'b1);                 lit("pwm50", 1'b1, 2'd2, 1'b0);
        body_pwm(128, 128, 1'b0);
        tick(1'b0);                 lit("pwm_full_mode_mid", 1'b1, 2'd3, 1'b0);
        body_n(125, 12, 1'b0);
        tick(1'b0);                 lit("len125", 1'b1, 2'd2, 1'b1);
        body_n(126, 12, 1'b0);
        tick(1'b0);                 lit("len126", 1'b1, 2'd2, 1'b0);
        body_n(130, 12, 1'b0);
        tick(1'b0);                 lit("len130", 1'b1, 2'd2, 1'b0);
        body_n(131, 12, 1'b1);
        tick(1'b0);                 lit("len131_mode_mid", 1'b1, 2'd2, 1'b1);
        body_n(300, 5, 1'b0);
        tick(1'b0);                 lit("no_tick", 1'b1, 2'd0, 1'b1);

        body_n(60, 6, 1'b0);
        cycle(1'b1, 1'b0, cur_din, 1'b0);  lit("rst_mid", 1'b0, 2'd0, 1'b0);
        cycle(1'b1, 1'b1, cur_din, 1'b1);  lit("rst_over_tick", 1'b0, 2'd0, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, cur_din, 1'b0);
        tick(1'b0);                 lit("rearm", 1'b0, 2'd0, 1'b0);
        body_n(128, 6, 1'b0);
        tick(1'b0);                 lit("post_rst", 1'b1, 2'd1, 1'b0);

        for (int s = 0; s < 60; s++) begin
            int gap;
            int p;
            bit r;
            tick(1'($urandom_range(1)));
            gap = ($urandom_range(9) == 0) ? int'($urandom_range(400, 200))
                                           : int'($urandom_range(136, 120));
            p = pr[$urandom_range(3)];
            for (int o = 1; o < gap; o++) begin
                if (int'($urandom_range(99)) < p) cur_din = ~cur_din;
                r = (s == 30 && o == 40) || ($urandom_range(1999) == 0);
                cycle(r, 1'b0, cur_din, 1'($urandom_range(1)));
            end
        end
        tick(1'b0);
        cycle(1'b0, 1'b0, cur_din, 1'b0);
        @(posedge clk);
        #3;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mfsk_demod_param.md
Name: mfsk_demod_param

Overview:
- Parametrised successor to the team's fixed 2-bit, 128-sample symbol demodulator.
- Recovers BITS-bit symbols from a 1-bit hard-limited baseband input.
- Two run-time modes:
  - FSK mode counts input transitions per symbol and compares the count against programmable thresholds.
  - PWM mode samples the input at evenly spaced points within the symbol and counts ones (thermometer decode).
- Sits between the channel slicer and the symbol-to-bit deframer. Symbol boundaries come from the external symbol timing block.

Parameters:
SPS, 128, nominal system-clock cycles per symbol (must be ≥ 2^(BITS+1))
BITS, 2, bits per symbol; M = 2^BITS levels
CNT_W, 8, width of position and transition counters (2^CNT_W > SPS)
THRESH, {8'd24,8'd12,8'd6}, (M-1) packed CNT_W-bit ascending thresholds T1..T(M-1); T1 in LSBs
TOL, 2, allowed |symbol length − SPS| before len_err is flagged

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
din  input  1  asynchronous hard-limited channel bit
sym_tick  input  1  one-cycle strobe marking the first cycle of each symbol
mode  input  1  0 = FSK transition count, 1 = PWM thermometer
dout  output  BITS  decided symbol
dout_valid  output  1  one-cycle strobe, dout is new
len_err  output  1  one-cycle strobe with dout_valid, completed symbol length out of tolerance

Behaviour:
- Synchroniser:
  - din passes through two flops to give din_s; a third flop gives din_d.
  - Edge = din_s ^ din_d.
  - All three flops reset to 0.
- Position counter pos:
  - sym_tick → 0.
  - Otherwise increments, saturating at 2^CNT_W−1.
- Transition counter tcnt:
  - sym_tick → edge, so an edge on the tick cycle belongs to the new symbol.
  - Otherwise tcnt + edge, saturating at 2^CNT_W−1.
- PWM sampling:
  - samp[j] <= din_s when pos == (2j+1)·SPS/2^(BITS+1), for j = 0..M−2.
  - For defaults the sample points are 16, 48 and 80.
  - samp clears on sym_tick.
- mode_q:
  - Latched from mode on sym_tick and applies to the symbol that starts then.
  - Mode changes mid-symbol have no effect until the next tick.
- Decision, made in the sym_tick cycle from the counters of the symbol just ending:
  - FSK: sym = number of j in 1..M−1 with tcnt ≥ Tj. Defaults: <6→0, 6–11→1, 12–23→2, ≥24→3.
  - PWM: sym = popcount(samp).
  - len = pos+1, saturating. Bad length when len < SPS−TOL or len > SPS+TOL.
- Output timing:
  - dout, dout_valid and len_err register one cycle after sym_tick (latency 1).
  - dout holds its value between strobes.
- Arming:
  - The first sym_tick after reset only arms the block; it produces no dout_valid.
  - An armed flag is set by that tick.
- No tick arrives: pos saturates, no output is produced, and the next tick reports len_err = 1.
- Reset mid-symbol clears all state; dout = 0, dout_valid = 0, len_err = 0, armed = 0.
- Reset has priority over sym_tick.

Test Plan:
- FSK decode: reset, tick, then 128 cycles of din toggling every 10 cycles (12 edges), tick → dout_valid one cycle after tick, dout = 2, len_err = 0.
- FSK threshold boundaries: edge counts 5, 6, 23, 24 in consecutive symbols → dout = 0, 1, 2, 3.
- PWM decode: mode = 1, din high for the first 50 cycles of the symbol, then low → samp = 011, dout = 2. With din high for the whole symbol → dout = 3.
- Length error: gaps between ticks of 125, 126, 130, 131 → len_err = 1, 0, 0, 1.
- Arming and mid-symbol mode change: no dout_valid on the first tick after reset; toggling mode mid-symbol does not change that symbol's decode.
- Reset mid-symbol: reset asserted at pos 60, then ticks resume → first tick gives no output, second tick decodes correctly; outputs are 0 during reset.
